// File: rtl/traffic_pkg.sv
// Shared lamp encodings, default phase durations and 7-segment glyphs.
// The light controller and the countdown display both import this package.
package traffic_pkg;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  localparam int GREEN_T_DEF  = 5;
  localparam int YELLOW_T_DEF = 1;
  localparam int ALLRED_T_DEF = 1;

  // Segment order is gfedcba and segments are active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    DIGIT_NS = 1'b0,
    DIGIT_EW = 1'b1
  } digit_t;

  function automatic logic lamp_legal(input logic [2:0] lamp);
    return (lamp == LT_RED) || (lamp == LT_YELLOW) || (lamp == LT_GREEN);
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] value);
    case (value)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/phase_countdown.sv
// One direction's lamp tracker: detects a phase change, loads that phase's
// duration and counts it down on each controller step, saturating at zero.
module phase_countdown
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = GREEN_T_DEF,
  parameter int YELLOW_T = YELLOW_T_DEF,
  parameter int RED_T    = GREEN_T_DEF + YELLOW_T_DEF + 2 * ALLRED_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [2:0] lamp,
  input  logic       conflict,
  output logic [3:0] rem,
  output logic       legal
);

  logic [2:0] prev;
  logic [3:0] dur;
  logic       changed;

  assign legal   = lamp_legal(lamp);
  assign changed = (lamp != prev);

  always_comb begin
    dur = 4'(RED_T);
    case (lamp)
      LT_GREEN:  dur = 4'(GREEN_T);
      LT_YELLOW: dur = 4'(YELLOW_T);
      default:   dur = 4'(RED_T);
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let prev's update leak into changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 3'b000;
      rem  <= 4'd0;
    end else begin
      prev <= lamp;
      // A bad pattern freezes the count; prev still follows so the next
      // good pattern is seen as a change and reloads.
      if (legal && !conflict) begin
        if (changed)
          rem <= dur;
        else if (step && rem != 4'd0)
          rem <= rem - 4'd1;
      end
    end
  end

endmodule

// File: rtl/light_countdown_display.sv
// Countdown display for the traffic-light lights bus: two phase counters,
// sticky fault detection and a two-digit multiplexed common-anode display.
module light_countdown_display
  import traffic_pkg::*;
#(
  parameter int GREEN_T     = GREEN_T_DEF,
  parameter int YELLOW_T    = YELLOW_T_DEF,
  parameter int ALLRED_T    = ALLRED_T_DEF,
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic [5:0] lights,
  output logic [3:0] ns_remain,
  output logic [3:0] ew_remain,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [1:0] fault
);

  localparam int RED_T = GREEN_T + YELLOW_T + 2 * ALLRED_T;
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (RED_T > 9) begin : g_red_too_long
    $error("light_countdown_display: RED_T exceeds one decimal digit");
  end
  if (REFRESH_DIV < 1) begin : g_bad_refresh
    $error("light_countdown_display: REFRESH_DIV must be at least 1");
  end

  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       ns_legal;
  logic       ew_legal;
  logic       conflict;

  assign ns_lamp  = lights[2:0];
  assign ew_lamp  = lights[5:3];
  assign conflict = (ns_lamp != LT_RED) && (ew_lamp != LT_RED);

  phase_countdown #(
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T),
    .RED_T   (RED_T)
  ) u_ns (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .lamp    (ns_lamp),
    .conflict(conflict),
    .rem     (ns_remain),
    .legal   (ns_legal)
  );

  phase_countdown #(
    .GREEN_T (GREEN_T),
    .YELLOW_T(YELLOW_T),
    .RED_T   (RED_T)
  ) u_ew (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .lamp    (ew_lamp),
    .conflict(conflict),
    .rem     (ew_remain),
    .legal   (ew_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault <= 2'b00;
    else
      fault <= fault | {conflict, !(ns_legal && ew_legal)};
  end

  logic [CW-1:0] refresh_cnt;
  digit_t        active;
  logic          wrap;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;

  assign wrap = (refresh_cnt == CW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      active      <= DIGIT_NS;
    end else if (wrap) begin
      refresh_cnt <= '0;
      active      <= (active == DIGIT_NS) ? DIGIT_EW : DIGIT_NS;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  always_comb begin
    an_next  = (active == DIGIT_NS) ? 2'b10 : 2'b01;
    seg_next = glyph((active == DIGIT_NS) ? ns_remain : ew_remain);
    if (fault != 2'b00)
      seg_next = SEG_DASH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_0;
      an  <= 2'b10;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_light_countdown_display.sv
// Directed bench for light_countdown_display at default parameters.
module tb_light_countdown_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [5:0] lights;
  logic [3:0] ns_remain;
  logic [3:0] ew_remain;
  logic [6:0] seg;
  logic [1:0] an;
  logic [1:0] fault;

  int checks = 0;
  int errors = 0;

  light_countdown_display #(
    .GREEN_T    (5),
    .YELLOW_T   (1),
    .ALLRED_T   (1),
    .REFRESH_DIV(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step     (step),
    .lights   (lights),
    .ns_remain(ns_remain),
    .ew_remain(ew_remain),
    .seg      (seg),
    .an       (an),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_rem(input string name, input logic [3:0] ns_exp,
                           input logic [3:0] ew_exp);
    checks++;
    if (ns_remain !== ns_exp || ew_remain !== ew_exp) begin
      errors++;
      $display("FAIL %s: ns=%0d ew=%0d, expected ns=%0d ew=%0d",
               name, ns_remain, ew_remain, ns_exp, ew_exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    step   = 1'b0;
    lights = 6'b000000;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    step   = 1'b0;
    lights = 6'b100001;
    cycles(2);
    check_rem("reset_rem", 4'd0, 4'd0);
    checks++;
    if (fault !== 2'b00 || an !== 2'b10 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: fault=%b an=%b seg=%b, expected 00 10 1000000",
               fault, an, seg);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_countdown();
    do_reset();
    lights = 6'b100001;
    step   = 1'b1;
    cycles(1);
    check_rem("first_load", 4'd5, 4'd8);
    cycles(4);
    check_rem("four_steps", 4'd1, 4'd4);
  endtask

  task automatic test_full_cycle();
    logic [5:0] pat [7] = '{6'b100001, 6'b100010, 6'b100100, 6'b001100,
                           6'b010100, 6'b100100, 6'b100001};
    int         len [7] = '{5, 1, 1, 5, 1, 1, 1};
    logic [3:0] ns_e[7] = '{4'd5, 4'd1, 4'd8, 4'd7, 4'd2, 4'd1, 4'd5};
    logic [3:0] ew_e[7] = '{4'd8, 4'd3, 4'd2, 4'd5, 4'd1, 4'd8, 4'd7};
    do_reset();
    step = 1'b1;
    for (int p = 0; p < 7; p++) begin
      lights = pat[p];
      cycles(1);
      check_rem($sformatf("cycle_phase%0d", p), ns_e[p], ew_e[p]);
      cycles(len[p] - 1);
    end
    checks++;
    if (fault !== 2'b00) begin
      errors++;
      $display("FAIL cycle_fault: fault=%b, expected 00", fault);
    end
    // Continues from NS=5 EW=7: two steps, then change lights while NS=3.
    cycles(2);
    check_rem("pre_coincident", 4'd3, 4'd5);
    lights = 6'b100100;
    cycles(1);
    check_rem("coincident_load", 4'd8, 4'd4);
  endtask

  task automatic test_sparse_step();
    do_reset();
    lights = 6'b100001;
    step   = 1'b0;
    cycles(1);
    check_rem("sparse_load", 4'd5, 4'd8);
    cycles(3);
    check_rem("sparse_hold", 4'd5, 4'd8);
    for (int g = 0; g < 7; g++) begin
      cycles(3);
      step = 1'b1;
      cycles(1);
      step = 1'b0;
      if (g == 4) check_rem("sparse_reach_zero", 4'd0, 4'd3);
    end
    check_rem("sparse_saturate", 4'd0, 4'd1);
  endtask

  task automatic test_fault();
    bit seen_ns;
    bit seen_ew;
    seen_ns = 1'b0;
    seen_ew = 1'b0;
    do_reset();
    lights = 6'b100001;
    step   = 1'b1;
    cycles(2);
    check_rem("fault_pre", 4'd4, 4'd7);
    lights = 6'b001001;
    cycles(1);
    check_rem("conflict_hold", 4'd4, 4'd7);
    checks++;
    if (fault !== 2'b10) begin
      errors++;
      $display("FAIL conflict_fault: fault=%b, expected 10", fault);
    end
    cycles(1);
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (an == 2'b10) seen_ns = 1'b1;
      if (an == 2'b01) seen_ew = 1'b1;
      checks++;
      if (seg !== 7'b0111111) begin
        errors++;
        $display("FAIL dash_seg: seg=%b an=%b, expected 0111111", seg, an);
      end
    end
    checks++;
    if (!(seen_ns && seen_ew)) begin
      errors++;
      $display("FAIL dash_both_digits: ns_seen=%0b ew_seen=%0b, expected 1 1",
               seen_ns, seen_ew);
    end
    check_rem("conflict_held_long", 4'd4, 4'd7);
    lights = 6'b100001;
    cycles(1);
    check_rem("recover_load", 4'd3, 4'd8);
    checks++;
    if (fault !== 2'b10) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b, expected 10", fault);
    end
    lights = 6'b110100;
    cycles(1);
    checks++;
    if (fault !== 2'b11) begin
      errors++;
      $display("FAIL encoding_fault: fault=%b, expected 11", fault);
    end
    reset = 1'b1;
    cycles(1);
    checks++;
    if (fault !== 2'b00 || ns_remain !== 4'd0 || ew_remain !== 4'd0) begin
      errors++;
      $display("FAIL midcount_reset: fault=%b ns=%0d ew=%0d, expected 00 0 0",
               fault, ns_remain, ew_remain);
    end
    reset = 1'b0;
  endtask

  task automatic test_display_mux();
    logic [1:0] an_e;
    logic [6:0] seg_e;
    do_reset();
    lights = 6'b100001;
    step   = 1'b0;
    cycles(1);
    for (int e = 2; e <= 12; e++) begin
      cycles(1);
      an_e  = (e >= 5 && e <= 8) ? 2'b01 : 2'b10;
      seg_e = (an_e == 2'b10) ? 7'b0010010 : 7'b0000000;
      checks++;
      if (an !== an_e || seg !== seg_e) begin
        errors++;
        $display("FAIL mux_edge%0d: an=%b seg=%b, expected an=%b seg=%b",
                 e, an, seg, an_e, seg_e);
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    step   = 1'b0;
    lights = 6'b000000;
    test_reset();
    test_basic_countdown();
    test_full_cycle();
    test_sparse_step();
    test_fault();
    test_display_mux();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
